// File: rtl/radix_conv_arbiter_if.sv
// Bundles the requester, converter and response handshakes of the radix converter arbiter.
// master: the arbiter's view. slave: the requesters and the converter together.
// The request, mode and data lanes are flat vectors, and requester i owns slice i.
interface radix_conv_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [2*NUM_REQ-1:0]  req_mode;
   logic [64*NUM_REQ-1:0] req_data;
   logic [1:0]            conv_ctrl;
   logic                  conv_in_valid;
   logic                  conv_in_ready;
   logic [63:0]           conv_in_data;
   logic                  conv_out_valid;
   logic                  conv_out_ready;
   logic [63:0]           conv_out_data;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [NUM_REQ-1:0]    rsp_ready;
   logic [63:0]           rsp_data;

   modport master (
      input  req_valid, req_mode, req_data, conv_in_ready,
             conv_out_valid, conv_out_data, rsp_ready,
      output req_ready, conv_ctrl, conv_in_valid, conv_in_data,
             conv_out_ready, rsp_valid, rsp_data
   );

   modport slave (
      output req_valid, req_mode, req_data, conv_in_ready,
             conv_out_valid, conv_out_data, rsp_ready,
      input  req_ready, conv_ctrl, conv_in_valid, conv_in_data,
             conv_out_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/radix_conv_arbiter.sv
// Purpose: shares one radix converter between NUM_REQ requesters. Arbitration is round-robin,
//          or fixed priority when RADIX_ARB_FIXED_PRIO_EN is defined. A tag FIFO routes each result back to its issuer.
// Latency: 1 cycle to arbitrate, then 1 beat per cycle; a mode switch waits for the converter to drain, plus 1 cycle.
// Backpressure: issue stalls on conv_in_ready or a full tag FIFO; results stall on the owner's rsp_ready.
module radix_conv_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int TAG_DEPTH = 16,
   parameter int MAX_BURST = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   radix_conv_arbiter_if.master bus
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int CW = $clog2(TAG_DEPTH + 1);
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, GRANT = 2'd2} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] g, g_nxt;
`ifndef RADIX_ARB_FIXED_PRIO_EN
   logic [IW-1:0] rr_ptr, rr_nxt;
`endif
   logic [1:0]    pend_mode, pend_nxt;
   logic [1:0]    ctrl, ctrl_nxt;
   logic [BW-1:0] beat_cnt, beat_nxt;

   logic [CW-1:0] inflight;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [IW-1:0] tag_mem [TAG_DEPTH];

   logic          found;
   logic [IW-1:0] w;
   logic [1:0]    w_mode, mode_g;
   logic          fifo_empty, issue_ok, push, pop, byp;
   logic [IW-1:0] head;
   logic [NUM_REQ-1:0] req_ready_q, rsp_valid_q;

   // Mode 3 is decoded by the converter as bypass, so it is folded onto 2 for every comparison
   function automatic logic [1:0] norm_mode(input logic [1:0] m);
      return (m == 2'd3) ? 2'd2 : m;
   endfunction

   assign mode_g     = norm_mode(bus.req_mode[2*int'(g) +: 2]);
   assign w_mode     = norm_mode(bus.req_mode[2*int'(w) +: 2]);
   assign fifo_empty = (inflight == '0);
   // The full check uses the registered count, so a pop in the same cycle does not open a slot
   assign issue_ok   = (state == GRANT) & bus.req_valid[g] & (mode_g == ctrl) &
                       (inflight < CW'(TAG_DEPTH));
   assign push       = issue_ok & bus.conv_in_ready;
   // With an empty FIFO the result can only belong to the current grant (bypass mode)
   assign head       = fifo_empty ? g : tag_mem[rd_ptr];
   assign pop        = bus.conv_out_valid & bus.conv_out_ready;
   assign byp        = push & pop & fifo_empty;

   // Winner search: the loop runs downward, so the last hit is the nearest candidate
   always_comb begin
      int idx;
      found = 1'b0;
      w     = '0;
      idx   = 0;
`ifdef RADIX_ARB_FIXED_PRIO_EN
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.req_valid[k]) begin
            found = 1'b1;
            w     = IW'(k);
         end
      end
`else
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (bus.req_valid[idx]) begin
            found = 1'b1;
            w     = IW'(idx);
         end
      end
`endif
   end

   // Next-state logic: arbitrate, drain on a mode change, and burst-limit the grant
   always_comb begin
      state_nxt = state;
      g_nxt     = g;
      pend_nxt  = pend_mode;
      ctrl_nxt  = ctrl;
      beat_nxt  = beat_cnt;
`ifndef RADIX_ARB_FIXED_PRIO_EN
      rr_nxt    = rr_ptr;
`endif
      case (state)
         IDLE: begin
            if (found) begin
               g_nxt    = w;
`ifndef RADIX_ARB_FIXED_PRIO_EN
               rr_nxt   = w;
`endif
               pend_nxt = w_mode;
               if ((w_mode == ctrl) || fifo_empty) begin
                  ctrl_nxt  = w_mode;
                  state_nxt = GRANT;
               end else begin
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (fifo_empty) begin
               ctrl_nxt  = pend_mode;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (!bus.req_valid[g] || (mode_g != ctrl)) begin
               state_nxt = IDLE;
               beat_nxt  = '0;
            end else if (push) begin
               if (beat_cnt == BW'(MAX_BURST - 1)) begin
                  state_nxt = IDLE;
                  beat_nxt  = '0;
               end else begin
                  beat_nxt = beat_cnt + BW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Arbiter state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         g         <= '0;
`ifndef RADIX_ARB_FIXED_PRIO_EN
         rr_ptr    <= IW'(NUM_REQ - 1);
`endif
         pend_mode <= 2'd0;
         ctrl      <= 2'd0;
         beat_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         g         <= g_nxt;
`ifndef RADIX_ARB_FIXED_PRIO_EN
         rr_ptr    <= rr_nxt;
`endif
         pend_mode <= pend_nxt;
         ctrl      <= ctrl_nxt;
         beat_cnt  <= beat_nxt;
      end
   end

   // Tag FIFO pointers and occupancy; a same-cycle push and pop on an empty FIFO bypasses storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         inflight <= '0;
      end else begin
         if (push && !byp) wr_ptr <= wr_ptr + PW'(1);
         if (pop && !fifo_empty) rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop) begin
            inflight <= inflight + CW'(1);
         end else if (pop && !push && !fifo_empty) begin
            inflight <= inflight - CW'(1);
         end
      end
   end

   // Tag storage holds requester indices only, so it needs no reset
   always_ff @(posedge clk) begin
      if (push && !byp) tag_mem[wr_ptr] <= g;
   end

   // Per-requester ready and response-valid decode
   always_comb begin
      req_ready_q    = '0;
      rsp_valid_q    = '0;
      req_ready_q[g] = push;
      if (bus.conv_out_valid) rsp_valid_q[head] = 1'b1;
   end

   assign bus.req_ready      = req_ready_q;
   assign bus.rsp_valid      = rsp_valid_q;
   assign bus.conv_ctrl      = ctrl;
   assign bus.conv_in_valid  = issue_ok;
   assign bus.conv_in_data   = bus.req_data[64*int'(g) +: 64];
   assign bus.conv_out_ready = bus.rsp_ready[head];
   assign bus.rsp_data       = bus.conv_out_data;
endmodule

// File: doc/radix_conv_arbiter.md
# radix_conv_arbiter

Sequencing arbiter that shares one half/single/double-to-double radix converter between NUM_REQ SpMV-kernel requesters. It selects a requester round-robin and drives the converter's 2-bit mode select. When a different mode is needed, it drains all in-flight beats before switching, because the converter's datapath muxing is combinational on the mode. Each issued beat's requester index goes into a tag FIFO, and every converted result is routed back to the requester that issued it.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- TAG_DEPTH, 16: maximum number of beats in flight inside the converter; this is the tag FIFO depth (power of 2).
- MAX_BURST, 8: maximum number of beats per grant before re-arbitration.
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_ready  out  NUM_REQ  per-requester beat accept.
- req_mode  in  2*NUM_REQ  per-requester mode: 0 = half→double, 1 = single→double, 2 = bypass, 3 = treated as 2.
- req_data  in  64*NUM_REQ  per-requester operand.
- conv_ctrl  out  2  converter mode select; registered.
- conv_in_valid / conv_in_ready  out/in  1  converter input handshake.
- conv_in_data  out  64  granted requester's data.
- conv_out_valid / conv_out_ready  in/out  1  converter result handshake.
- conv_out_data  in  64  converter result.
- rsp_valid / rsp_ready  out/in  NUM_REQ  per-requester result handshake.
- rsp_data  out  64  equals conv_out_data, broadcast to all requesters.

## Operation
- The state machine has three states: IDLE, DRAIN and GRANT. inflight is the tag FIFO occupancy, $clog2(TAG_DEPTH+1) bits wide.
- IDLE:
  - The arbiter picks w, the first requester with req_valid set, searching from rr_ptr+1 upward with wrap.
  - It registers g←w, rr_ptr←w and pend_mode←req_mode[w].
  - If pend_mode equals conv_ctrl, or inflight is 0, then conv_ctrl←pend_mode and the next state is GRANT. Otherwise the next state is DRAIN.
- DRAIN:
  - conv_in_valid=0 and all req_ready=0.
  - When inflight reaches 0: conv_ctrl←pend_mode, next state GRANT.
- GRANT:
  - Issue condition: issue_ok = req_valid[g] & (req_mode[g]==conv_ctrl) & (inflight<TAG_DEPTH).
  - conv_in_valid = issue_ok; conv_in_data = req_data[g]; req_ready[g] = issue_ok & conv_in_ready. All other req_ready are 0.
  - Each handshake pushes g into the tag FIFO and increments beat_cnt.
  - Return to IDLE, and clear beat_cnt, when any of these holds:
    - req_valid[g] is 0;
    - req_mode[g] differs from conv_ctrl (no beat is issued in that cycle);
    - a handshake makes beat_cnt reach MAX_BURST.
- Return path:
  - head = tag FIFO head when the FIFO is non-empty, otherwise g. This fall-through covers bypass mode, where the result appears in the same cycle as the input.
  - rsp_valid[i] = conv_out_valid & (head==i); conv_out_ready = rsp_ready[head].
  - A handshake pops the FIFO.
  - A push and a pop in the same cycle leave inflight unchanged. In bypass mode with an empty FIFO, the simultaneous push and pop bypass the FIFO storage and inflight stays 0.
- Full FIFO: a pop does not free a slot for a push in the same cycle; inflight<TAG_DEPTH is evaluated on the registered count.

## Timing
- Reset values:
  - state=IDLE, conv_ctrl=0, rr_ptr=NUM_REQ-1 (requester 0 wins first), FIFO empty, beat_cnt=0.
  - All req_ready, rsp_valid and conv_in_valid are 0; conv_out_ready is 0 unless rsp_ready[g] is set.
- Arbitration costs 1 cycle: request seen in IDLE → first beat possible on the next cycle.
- Mode switch cost: drain time plus 1 cycle. conv_ctrl never changes while inflight≠0.
- The first beat after a switch is issued in the cycle after the conv_ctrl update.
- Back-to-back beats: 1 per cycle within a grant; 1 idle cycle between grants.
- Reset asserted mid-operation: all state clears immediately and in-flight tags are discarded. The converter is reset alongside on the same reset.

## Configuration
- RADIX_ARB_FIXED_PRIO_EN
  - Defined: IDLE picks the lowest-index valid requester and rr_ptr is unused.
  - Undefined (default): round-robin as described above.

## Test plan
- Single requester 0, mode 1, 5 beats, converter latency 6 → conv_ctrl=1, 5 results on rsp 0 in order, inflight peaks at 5 and returns to 0.
- Requester 0 in mode 0 with 3 beats in flight; requester 1 requests mode 2 → DRAIN until all 3 results pop, conv_ctrl changes 0→2 exactly when inflight==0, and requester 1's beats return in the same cycle as issue.
- Requesters 0..3 all valid with mode 1, MAX_BURST=8, continuous traffic → grants 0,1,2,3,0 in bursts of exactly 8. With RADIX_ARB_FIXED_PRIO_EN defined, requester 0 wins every arbitration.
- rsp_ready held low with TAG_DEPTH=16 → exactly 16 beats issued, then conv_in_valid=0 until the first pop. The next issue occurs one cycle after the pop.
- Requester changes req_mode mid-burst from 1 to 0 → no beat issued in that cycle, state returns to IDLE, then DRAIN precedes the mode-0 grant.
- Reset asserted with 4 beats in flight → next cycle all valids are 0, inflight=0 and conv_ctrl=0.
